// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Holds the tag/data arrays, stalls the CPU on a miss, writes back a dirty
// victim, refills the line from the 256-bit memory, then completes as a hit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no memory traffic; hits served combinationally
// S_MISS     | one-cycle decision: dirty victim -> write-back, else refill
// S_WB       | victim line driven to memory, wait for ack
// S_RM       | refill read of requested line, wait for ack
// S_RMOK     | one settle cycle before the access hits in S_IDLE
module dcache_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int NUM_LINES = 32,
    parameter int TAG_W     = 22
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int ENT_W = TAG_W + 2;
    localparam int VBIT  = TAG_W + 1;
    localparam int DBIT  = TAG_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MISS = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RM   = 3'd3;
    localparam logic [2:0] S_RMOK = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [ADDR_W-1:OFF_W]   miss_addr_q, miss_addr_d;
    logic [ENT_W-1:0]        tag_q  [NUM_LINES];
    logic [LINE_W-1:0]       data_q [NUM_LINES];

    logic                    req, hit;
    logic [IDX_W-1:0]        cur_idx, miss_idx;
    logic [TAG_W-1:0]        cur_tag, miss_tag;
    logic [2:0]              wsel;
    logic [ENT_W-1:0]        cur_entry, victim;
    logic [LINE_W-1:0]       cur_line;

    logic                    tag_we, data_we;
    logic [IDX_W-1:0]        tag_widx, data_widx;
    logic [ENT_W-1:0]        tag_d;
    logic [LINE_W-1:0]       data_d;

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign req       = p1_MemRead_i | p1_MemWrite_i;
    assign cur_idx   = p1_addr_i[OFF_W +: IDX_W];
    assign cur_tag   = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel      = p1_addr_i[4:2];
    assign cur_entry = tag_q[cur_idx];
    assign cur_line  = data_q[cur_idx];
    assign hit       = cur_entry[VBIT] & (cur_entry[TAG_W-1:0] == cur_tag);
    assign miss_idx  = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign victim    = tag_q[miss_idx];

    assign p1_stall_o = req & ((state_q != S_IDLE) | ~hit);
    assign p1_data_o  = p1_MemRead_i ? cur_line[32*wsel +: 32] : 32'd0;

    // Next state, miss address capture and array write requests.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        tag_we      = 1'b0;
        tag_widx    = cur_idx;
        tag_d       = cur_entry;
        data_we     = 1'b0;
        data_widx   = cur_idx;
        data_d      = cur_line;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d = S_MISS;
                end else if (req && p1_MemWrite_i) begin
                    data_we                = 1'b1;
                    data_d[32*wsel +: 32]  = p1_data_i;
                    tag_we                 = 1'b1;
                    tag_d[DBIT]            = 1'b1;
                end
            end
            S_MISS: begin
                miss_addr_d = p1_addr_i[ADDR_W-1:OFF_W];
                state_d     = (cur_entry[VBIT] && cur_entry[DBIT]) ? S_WB : S_RM;
            end
            S_WB: begin
                if (mem_ack_i) begin
                    tag_we      = 1'b1;
                    tag_widx    = miss_idx;
                    tag_d       = victim;
                    tag_d[DBIT] = 1'b0;
                    state_d     = S_RM;
                end
            end
            S_RM: begin
                if (mem_ack_i) begin
                    tag_we    = 1'b1;
                    tag_widx  = miss_idx;
                    tag_d     = {1'b1, 1'b0, miss_tag};
                    data_we   = 1'b1;
                    data_widx = miss_idx;
                    data_d    = mem_data_i;
                    state_d   = S_RMOK;
                end
            end
            S_RMOK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory request decoded purely from state so it holds for the whole wait.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (state_q == S_WB) begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {victim[TAG_W-1:0], miss_idx, {OFF_W{1'b0}}};
            mem_data_o   = data_q[miss_idx];
        end else if (state_q == S_RM) begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        end
    end

    // State, miss address and tag array; reset invalidates every line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (tag_we) begin
                tag_q[tag_widx] <= tag_d;
            end
        end
    end

    // Data array has no reset; a line is only read once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[data_widx] <= data_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: clean/dirty read misses, write hit,
// write miss, slow memory and reset in the middle of a refill.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_MemRead_i, p1_MemWrite_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i, mem_data_o;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o, mem_write_o;

    dcache_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    logic [255:0] mem_model [128];

    int           total_cnt = 0;
    int           pass_cnt  = 0;

    int           stall_cyc, n_ref, n_wb;
    logic [31:0]  wb_addr, rf_addr, rdata;
    logic [255:0] wb_data;
    logic         addr_stable;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One CPU access; acts as the memory, acking on the lat-th enabled cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int          wcnt;
        logic        prev_en, prev_wr;
        logic [31:0] first_addr;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = a;
        p1_data_i     = d;
        stall_cyc = 0; n_ref = 0; n_wb = 0; addr_stable = 1'b1;
        wb_addr = '0; rf_addr = '0; wb_data = '0;
        wcnt = 0; prev_en = 1'b0; prev_wr = 1'b0; first_addr = '0;
        @(negedge clk_i);
        while (p1_stall_o && stall_cyc < 200) begin
            stall_cyc++;
            if (mem_enable_o) begin
                if (!prev_en || prev_wr != mem_write_o) begin
                    wcnt = 0;
                    first_addr = mem_addr_o;
                end else if (mem_addr_o !== first_addr) begin
                    addr_stable = 1'b0;
                end
                wcnt++;
                if (wcnt >= lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) begin
                        n_wb++;
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                        mem_model[mem_addr_o[11:5]] = mem_data_o;
                    end else begin
                        n_ref++;
                        rf_addr = mem_addr_o;
                        mem_data_i = mem_model[mem_addr_o[11:5]];
                    end
                end
            end
            prev_en = mem_enable_o;
            prev_wr = mem_write_o;
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            @(negedge clk_i);
        end
        chk("stall_bound", 256'(stall_cyc < 200), 256'(1));
        rdata = p1_data_o;
        @(posedge clk_i);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int valid_cnt;
        mem_model[0]  = 256'h5;
        mem_model[1]  = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        mem_model[32] = 256'h77;
        mem_model[64] = 256'h99;
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        p1_addr_i = '0; p1_data_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;

        #2;
        chk("rst_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_stall", 256'(p1_stall_o), 256'(0));
        chk("rst_rdata", 256'(p1_data_o), 256'(0));
        chk("rst_tag0", 256'(dut.tag_q[0]), 256'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // 1: clean read miss
        access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1);
        chk("t1_stall_cycles", 256'(stall_cyc), 256'(4));
        chk("t1_refills", 256'(n_ref), 256'(1));
        chk("t1_writebacks", 256'(n_wb), 256'(0));
        chk("t1_refill_addr", 256'(rf_addr), 256'(32'h0));
        chk("t1_rdata", 256'(rdata), 256'(32'h5));
        chk("t1_tag", 256'(dut.tag_q[0]), 256'(24'h800000));

        // 2: write hit
        access(1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1);
        chk("t2_stall_cycles", 256'(stall_cyc), 256'(0));
        chk("t2_word", 256'(dut.data_q[0][63:32]), 256'(32'hDEAD_BEEF));
        chk("t2_tag", 256'(dut.tag_q[0]), 256'(24'hC00000));
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1);
        chk("t2_readback", 256'(rdata), 256'(32'hDEAD_BEEF));

        // 3: conflicting dirty miss
        access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1);
        chk("t3_stall_cycles", 256'(stall_cyc), 256'(5));
        chk("t3_writebacks", 256'(n_wb), 256'(1));
        chk("t3_wb_addr", 256'(wb_addr), 256'(32'h0));
        chk("t3_wb_data", 256'(wb_data[63:0]), 256'({32'hDEAD_BEEF, 32'h5}));
        chk("t3_refill_addr", 256'(rf_addr), 256'(32'h400));
        chk("t3_rdata", 256'(rdata), 256'(32'h77));
        chk("t3_tag", 256'(dut.tag_q[0]), 256'(24'h800001));

        // 4: clean write miss
        access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 1);
        chk("t4_writebacks", 256'(n_wb), 256'(0));
        chk("t4_refills", 256'(n_ref), 256'(1));
        chk("t4_refill_addr", 256'(rf_addr), 256'(32'h20));
        chk("t4_word1", 256'(dut.data_q[1][63:32]), 256'(32'h1234_5678));
        chk("t4_word0", 256'(dut.data_q[1][31:0]), 256'(32'h1));
        chk("t4_tag", 256'(dut.tag_q[1]), 256'(24'hC00000));

        // 5: slow memory, ack on the 10th refill cycle
        access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 10);
        chk("t5_stall_cycles", 256'(stall_cyc), 256'(13));
        chk("t5_refills", 256'(n_ref), 256'(1));
        chk("t5_writebacks", 256'(n_wb), 256'(0));
        chk("t5_addr_stable", 256'(addr_stable), 256'(1));
        chk("t5_refill_addr", 256'(rf_addr), 256'(32'h800));
        chk("t5_rdata", 256'(rdata), 256'(32'h99));

        // 6: reset during refill wait
        p1_MemRead_i = 1'b1;
        p1_addr_i    = 32'h0000_1000;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_in_refill", 256'({mem_enable_o, mem_write_o}), 256'(2'b10));
        rst_i = 1'b1;
        #1;
        chk("t6_rst_enable", 256'(mem_enable_o), 256'(0));
        chk("t6_rst_write", 256'(mem_write_o), 256'(0));
        chk("t6_rst_stall_req", 256'(p1_stall_o), 256'(1));
        p1_MemRead_i = 1'b0;
        #1;
        chk("t6_rst_stall_idle", 256'(p1_stall_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("t6_late_ack_enable", 256'(mem_enable_o), 256'(0));
        chk("t6_late_ack_stall", 256'(p1_stall_o), 256'(0));
        valid_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.tag_q[i][23]) valid_cnt++;
        end
        chk("t6_valid_count", 256'(valid_cnt), 256'(0));
        chk("t6_tag0", 256'(dut.tag_q[0]), 256'(0));
        @(posedge clk_i);
        #1;
        access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1);
        chk("t6_post_stall_cycles", 256'(stall_cyc), 256'(4));
        chk("t6_post_rdata", 256'(rdata), 256'(32'h5));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
